clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
// PURPOSE
//  Parametrised multi-channel programmable clock-enable divider; successor to the fixed single-output divider.
//  CHANNELS independent outputs derive from clock_in, each with a runtime-loadable divide ratio and an enable.
//  Outputs are registered, near-50% duty strobes plus a one-cycle tick per period; they are not used as clocks.
//  Sits between the board clock and slow peripherals (LED blink, UART baud, scan timers).
// PARAMETERS
//  CHANNELS     4    number of independent divider channels (1..16)
//  WIDTH        16   divide-ratio / counter width in bits
//  DEFAULT_DIV  2    ratio loaded into every channel on reset (2..2^WIDTH-1)
// PORTS
//  clock_in    in   1                    single system clock; all logic on posedge
//  reset       in   1                    synchronous, active-high reset
//  enable      in   CHANNELS             per-channel run enable, level sensitive
//  div_load    in   1                    one-cycle request to load a new ratio
//  div_ch      in   $clog2(CHANNELS)+1   target channel index for div_load
//  div_value   in   WIDTH                requested divide ratio D
//  load_ack    out  1                    registered pulse, cycle after an accepted load
//  clock_out   out  CHANNELS             divided output per channel
//  tick        out  CHANNELS             one-cycle pulse on each clock_out rising edge
// BEHAVIOUR
//  Reset (sync, high): cnt=0, active_div=DEFAULT_DIV, pend_valid=0, clock_out=0, tick=0, load_ack=0.
//  Reset mid-period aborts all periods and discards pending loads; reset has priority over everything.
//  Per-channel state: cnt[WIDTH], active_div[WIDTH], pend_div[WIDTH], pend_valid.
//  Ratio D clamp: div_value < 2 is stored as 2; no other arithmetic on D.
//  Duty: H = (D+1)>>1 high cycles, then D-H low cycles; even D gives 50%, odd D gives one extra high cycle.
//  Running (enable[i]=1): cnt counts 0..D-1 and wraps to 0; clock_out[i] registered = (cnt < H).
//  First output cycle after enable is sampled high is a high cycle with tick=1 (cnt=0 at that edge).
//  tick[i]=1 exactly in the cycle clock_out[i] goes 0->1 (cnt==0); never asserted while disabled.
//  Load: div_load=1 with div_ch<CHANNELS -> pend_div[div_ch]=clamp(div_value), pend_valid=1.
//    load_ack=1 next cycle; div_ch>=CHANNELS is ignored, no ack, no state change.
//  Two loads to one channel before it is applied: the last wins; one ack per accepted load.
//  Apply point (glitch-free): at the wrap (cnt==active_div-1 -> 0), active_div<=pend_div, pend_valid<=0.
//  Load in the same cycle as the wrap stays pending and applies at the next wrap.
//  Disabled (enable[i]=0): next cycle cnt=0, clock_out[i]=0, tick[i]=0; a pending ratio applies immediately.
//  Enable drop mid-high-phase truncates the period (no completion); re-enable restarts at cnt=0.
//  Channels are fully independent; one load port, one channel per cycle.
//  Latency: enable rise at edge k -> clock_out high and tick from edge k+1.
// TESTING
//  T1 reset, enable[0]=1, DEFAULT_DIV=2 -> clock_out[0] toggles each cycle 1,0,1,0; tick on every high cycle.
//  T2 load ch1 D=5, enable[1] -> 3 high, 2 low repeating; tick every 5 cycles; load_ack one cycle after load.
//  T3 ch2 running D=4; load D=6 at cnt=1 -> current 4-cycle period completes, then 3 high / 3 low.
//  T4 load div_ch=CHANNELS, D=9 -> no load_ack, all ratios unchanged; load D=0 -> behaves as D=2.
//  T5 enable[3] dropped at cnt=1 of D=8 -> clock_out[3]=0 next cycle; re-enable -> tick, 4 high / 4 low.
//  T6 reset asserted mid-period with pending D=7 -> outputs 0 next cycle; after release ratio is DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock-enable divider: registered near-50% strobes plus a per-period tick.
// Latency: enable sampled at edge k -> clock_out/tick from edge k+1; load_ack one cycle after div_load.
// No backpressure: a load is accepted every cycle; a new ratio takes effect at the wrap, or at once when the channel is disabled.
module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                         clock_in,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          enable,
    input  logic                         div_load,
    input  logic [$clog2(CHANNELS):0]    div_ch,
    input  logic [WIDTH-1:0]             div_value,
    output logic                         load_ack,
    output logic [CHANNELS-1:0]          clock_out,
    output logic [CHANNELS-1:0]          tick
);
    localparam int                CHW    = $clog2(CHANNELS) + 1;
    localparam logic [CHW-1:0]    NUM_CH = CHW'(CHANNELS);
    localparam logic [WIDTH-1:0]  DEF    = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0]  MIN_D  = WIDTH'(2);

    logic             load_ok;
    logic [WIDTH-1:0] load_val;

    always_comb begin
        load_ok  = div_load && (div_ch < NUM_CH);
        load_val = (div_value < MIN_D) ? MIN_D : div_value;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            load_ack <= 1'b0;
        end else begin
            load_ack <= load_ok;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] active_div;
        logic [WIDTH-1:0] pend_div;
        logic             pend_valid;
        logic             co_q;
        logic             tick_q;
        logic [WIDTH:0]   high_len;
        logic             wrap;
        logic             load_here;

        // Odd ratios give the extra cycle to the high phase.
        assign high_len  = ({1'b0, active_div} + (WIDTH+1)'(1)) >> 1;
        assign wrap      = (cnt == active_div - WIDTH'(1));
        assign load_here = load_ok && (div_ch == CHW'(g));

        always_ff @(posedge clock_in) begin
            if (reset) begin
                cnt        <= '0;
                active_div <= DEF;
                pend_div   <= DEF;
                pend_valid <= 1'b0;
                co_q       <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                // A load landing on the wrap cycle stays pending until the next wrap.
                if (load_here) begin
                    pend_div   <= load_val;
                    pend_valid <= 1'b1;
                end else if (pend_valid && (!enable[g] || wrap)) begin
                    active_div <= pend_div;
                    pend_valid <= 1'b0;
                end

                if (!enable[g]) begin
                    cnt    <= '0;
                    co_q   <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    co_q   <= ({1'b0, cnt} < high_len);
                    tick_q <= (cnt == '0);
                    cnt    <= wrap ? '0 : cnt + WIDTH'(1);
                end
            end
        end

        assign clock_out[g] = co_q;
        assign tick[g]      = tick_q;
    end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed stimulus pushes per-cycle expectations into a queue; a negedge monitor pops and compares.
module tb_clock_divider_bank;
    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [CH-1:0] enable    = '0;
    logic          div_load  = 1'b0;
    logic [2:0]    div_ch    = '0;
    logic [W-1:0]  div_value = '0;
    logic          load_ack;
    logic [CH-1:0] clock_out;
    logic [CH-1:0] tick;

    typedef struct {
        int        cyc;
        string     name;
        logic [3:0] cm;
        logic [3:0] ce;
        logic [3:0] tm;
        logic [3:0] te;
        bit        ak_chk;
        bit        ak;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    clock_divider_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
        .clock_in  (clk),
        .reset     (reset),
        .enable    (enable),
        .div_load  (div_load),
        .div_ch    (div_ch),
        .div_value (div_value),
        .load_ack  (load_ack),
        .clock_out (clock_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation applies to the outputs after the next rising edge.
    task automatic step(input string name, input logic [3:0] cm, input logic [3:0] ce,
                        input logic [3:0] tm, input logic [3:0] te, input bit akc, input bit ak);
        exp_t e;
        e.cyc = cyc + 1; e.name = name;
        e.cm = cm; e.ce = ce; e.tm = tm; e.te = te;
        e.ak_chk = akc; e.ak = ak;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ch(input string name, input int ch, input bit co, input bit tk,
                          input bit akc, input bit ak);
        logic [3:0] msk;
        msk = 4'(1) << ch;
        step(name, msk, co ? msk : 4'h0, msk, tk ? msk : 4'h0, akc, ak);
    endtask

    task automatic load(input logic [2:0] ch, input logic [W-1:0] val);
        div_load = 1'b1; div_ch = ch; div_value = val;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            tests++;
            if (m.cyc != cyc || ((clock_out & m.cm) != m.ce) || ((tick & m.tm) != m.te) ||
                (m.ak_chk && (load_ack != m.ak))) begin
                fails++;
                $display("FAIL %s cyc=%0d: got clock_out=%b tick=%b load_ack=%b; want clock_out=%b tick=%b (mask %b/%b) load_ack=%b",
                         m.name, cyc, clock_out, tick, load_ack, m.ce, m.te, m.cm, m.tm, m.ak);
            end
        end
    end

    initial begin
        step("reset", 4'hF, 4'h0, 4'hF, 4'h0, 1, 0);
        step("reset", 4'hF, 4'h0, 4'hF, 4'h0, 1, 0);
        reset = 1'b0;

        // T1: default ratio 2 toggles every cycle
        enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) chk_ch("t1_div2", 0, (k % 2) == 0, (k % 2) == 0, 1, 0);
        enable[0] = 1'b0;
        chk_ch("t1_off", 0, 0, 0, 1, 0);

        // T2: D=5 -> 3 high / 2 low
        load(1, 16'd5);
        chk_ch("t2_ack", 1, 0, 0, 1, 1);
        div_load = 1'b0;
        chk_ch("t2_idle", 1, 0, 0, 1, 0);
        enable[1] = 1'b1;
        for (int k = 0; k < 10; k++) chk_ch("t2_div5", 1, (k % 5) < 3, (k % 5) == 0, 1, 0);
        enable[1] = 1'b0;
        chk_ch("t2_off", 1, 0, 0, 1, 0);

        // T3: D=4 running, D=6 loaded mid-period applies at the wrap
        load(2, 16'd4);
        chk_ch("t3_ack4", 2, 0, 0, 1, 1);
        div_load = 1'b0;
        chk_ch("t3_idle", 2, 0, 0, 1, 0);
        enable[2] = 1'b1;
        chk_ch("t3_p0", 2, 1, 1, 1, 0);
        load(2, 16'd6);
        chk_ch("t3_p1_ack6", 2, 1, 0, 1, 1);
        div_load = 1'b0;
        chk_ch("t3_p2", 2, 0, 0, 1, 0);
        chk_ch("t3_p3", 2, 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) chk_ch("t3_div6", 2, (k % 6) < 3, (k % 6) == 0, 1, 0);
        enable[2] = 1'b0;
        chk_ch("t3_off", 2, 0, 0, 1, 0);

        // T4: out-of-range channel ignored; D=0 clamps to 2
        load(3'd4, 16'd9);
        step("t4_bad_noack", 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
        div_load = 1'b0;
        chk_ch("t4_idle", 0, 0, 0, 1, 0);
        enable[0] = 1'b1;
        for (int k = 0; k < 4; k++) chk_ch("t4_ch0_div2", 0, (k % 2) == 0, (k % 2) == 0, 1, 0);
        enable[0] = 1'b0;
        chk_ch("t4_off", 0, 0, 0, 1, 0);
        load(0, 16'd0);
        chk_ch("t4_ack0", 0, 0, 0, 1, 1);
        div_load = 1'b0;
        chk_ch("t4_idle0", 0, 0, 0, 1, 0);
        enable[0] = 1'b1;
        for (int k = 0; k < 6; k++) chk_ch("t4_clamp", 0, (k % 2) == 0, (k % 2) == 0, 1, 0);
        enable[0] = 1'b0;
        chk_ch("t4_off0", 0, 0, 0, 1, 0);

        // T5: two loads (last wins, two acks), then enable drop mid-high and restart
        load(3, 16'd3);
        chk_ch("t5_ack_a", 3, 0, 0, 1, 1);
        load(3, 16'd8);
        chk_ch("t5_ack_b", 3, 0, 0, 1, 1);
        div_load = 1'b0;
        chk_ch("t5_idle", 3, 0, 0, 1, 0);
        enable[3] = 1'b1;
        chk_ch("t5_p0", 3, 1, 1, 1, 0);
        chk_ch("t5_p1", 3, 1, 0, 1, 0);
        enable[3] = 1'b0;
        chk_ch("t5_drop", 3, 0, 0, 1, 0);
        chk_ch("t5_drop2", 3, 0, 0, 1, 0);
        enable[3] = 1'b1;
        for (int k = 0; k < 12; k++) chk_ch("t5_div8", 3, (k % 8) < 4, (k % 8) == 0, 1, 0);
        enable[3] = 1'b0;
        chk_ch("t5_off", 3, 0, 0, 1, 0);

        // T6: reset mid-period discards pending D=7 and restores the default ratio
        enable[1] = 1'b1;
        chk_ch("t6_p0", 1, 1, 1, 1, 0);
        chk_ch("t6_p1", 1, 1, 0, 1, 0);
        load(1, 16'd7);
        chk_ch("t6_ack7", 1, 1, 0, 1, 1);
        div_load = 1'b0;
        reset = 1'b1;
        step("t6_reset", 4'hF, 4'h0, 4'hF, 4'h0, 1, 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) chk_ch("t6_default", 1, (k % 2) == 0, (k % 2) == 0, 1, 0);
        enable[1] = 1'b0;
        chk_ch("t6_off", 1, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
